host_specific_top_tx_to_host: RTL and testbench

Return path of the host-specific top level: accepts a 144-bit BLE packet from the radio side and validates preamble, access address, header and CRC-24. It then OTP-decrypts the payload unless bypassed and streams a byte-framed response to the host UART transmitter over a valid/ready handshake. It is the receive-from-air / transmit-to-host counterpart of the host-to-air command path.

---
 rtl/host_specific_top_tx_to_host.sv | 234 +++++++++++++++++++++++
 tb/tb_host_specific_top_tx_to_host.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_specific_top_tx_to_host.sv
// host_specific_top_tx_to_host
// Return path of the host-specific top level. A 144-bit BLE packet from the
// radio side is latched, its header and CRC-24 are checked, the payload is
// one-time-pad decrypted (unless bypassed), and a byte frame
//   7E, cmd, len, payload bytes (MSB first), checksum
// is streamed to the host UART over a valid/ready handshake.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   packet_in       : BLE packet, sampled on the accept edge
//   packet_valid    : packet offer (level)
//   decrypt_bypass  : 1 = send payload without XOR, sampled on accept
//   ready           : idle and able to accept
//   tx_data/tx_valid/tx_ready : byte stream to host UART
//   done            : one-cycle pulse after the last byte transfers
//   error/error_code: sticky error flag, 1 = header, 2 = CRC, 3 = length
//   dropped         : pulse per cycle packet_valid is seen while busy
//   good_count      : frames sent, wraps at 255
module host_specific_top_tx_to_host #(
  parameter logic [15:0] KEY         = 16'hA5C3,
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [143:0] packet_in,
  input  logic         packet_valid,
  input  logic         decrypt_bypass,
  output logic         ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         done,
  output logic         error,
  output logic [1:0]   error_code,
  output logic         dropped,
  output logic [7:0]   good_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CRC, S_DEC, S_SEND
  } state_t;

  localparam logic [23:0] CRC_INIT = 24'h555555;
  localparam logic [23:0] CRC_POLY = 24'h00065B;

  state_t state, state_d;

  // Latched packet; the low 32 bits carry nothing of interest.
  logic [143:32] pkt;
  logic          byp;
  logic [23:0]   crc;
  logic [47:0]   crc_sh;
  logic [5:0]    crc_cnt;
  logic [31:0]   pay;
  logic [7:0]    csum;
  logic [2:0]    idx;

  logic unused_low;
  assign unused_low = ^packet_in[31:0];

  // Header field decode
  logic [7:0] cmd, len;
  logic       len4, hdr_bad, len_bad, crc_bad, last_byte;
  assign cmd       = pkt[103:96];
  assign len       = pkt[95:88];
  assign len4      = (len == 8'd4);
  assign hdr_bad   = (pkt[143:136] != 8'hAA) || (pkt[135:104] != ACCESS_ADDR) ||
                     (cmd[7:4] != 4'h0) || (cmd[3:0] == 4'h0);
  assign len_bad   = (len != 8'd2) && (len != 8'd4);
  assign crc_bad   = (crc != pkt[55:32]);
  assign last_byte = (idx == (len4 ? 3'd7 : 3'd5));

  // Decrypted payload and checksum, loaded into pay/csum in DEC.
  // For len 2 only the low half is meaningful, so only it gets the pad.
  logic [31:0] pay_dec;
  logic [7:0]  csum_dec;
  always_comb begin
    pay_dec = pkt[87:56];
    if (!byp) pay_dec = pkt[87:56] ^ (len4 ? {KEY, KEY} : {16'h0000, KEY});
    csum_dec = cmd ^ len ^ pay_dec[15:8] ^ pay_dec[7:0];
    if (len4) csum_dec = csum_dec ^ pay_dec[31:24] ^ pay_dec[23:16];
  end

  // Outgoing frame, indexed by byte position
  logic [7:0] frame [8];
  always_comb begin
    for (int i = 0; i < 8; i++) frame[i] = 8'h00;
    frame[0] = 8'h7E;
    frame[1] = cmd;
    frame[2] = len;
    if (len4) begin
      frame[3] = pay[31:24];
      frame[4] = pay[23:16];
      frame[5] = pay[15:8];
      frame[6] = pay[7:0];
      frame[7] = csum;
    end else begin
      frame[3] = pay[15:8];
      frame[4] = pay[7:0];
      frame[5] = csum;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (packet_valid)                state_d = S_HDR;
      S_HDR:  state_d = (hdr_bad || len_bad) ? S_IDLE : S_CRC;
      S_CRC:  if (crc_cnt == 6'd47)            state_d = S_DEC;
      S_DEC:  state_d = crc_bad ? S_IDLE : S_SEND;
      S_SEND: if (tx_valid && tx_ready && last_byte) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  logic       ready_d, tx_valid_d, done_d, error_d, dropped_d;
  logic [7:0] tx_data_d, good_d;
  logic [1:0] code_d;
  logic [2:0] idx_nxt;
  assign idx_nxt = idx + 3'd1;

  always_comb begin
    ready_d    = ready;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    done_d     = 1'b0;
    error_d    = error;
    code_d     = error_code;
    good_d     = good_count;
    dropped_d  = packet_valid && (state != S_IDLE);
    case (state)
      S_IDLE: if (packet_valid) begin
        ready_d = 1'b0;
        error_d = 1'b0;
        code_d  = 2'd0;
      end
      S_HDR: begin
        if (hdr_bad) begin
          error_d = 1'b1; code_d = 2'd1; ready_d = 1'b1;
        end else if (len_bad) begin
          error_d = 1'b1; code_d = 2'd3; ready_d = 1'b1;
        end
      end
      S_DEC: if (crc_bad) begin
        error_d = 1'b1; code_d = 2'd2; ready_d = 1'b1;
      end
      S_SEND: begin
        // tx_valid is low only on the first SEND cycle: present the flag byte.
        if (!tx_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = frame[0];
        end else if (tx_ready) begin
          if (last_byte) begin
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            ready_d    = 1'b1;
            good_d     = good_count + 8'd1;
          end else begin
            tx_data_d = frame[idx_nxt];
          end
        end
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= 2'd0;
      dropped    <= 1'b0;
      good_count <= 8'h00;
    end else begin
      state      <= state_d;
      ready      <= ready_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      done       <= done_d;
      error      <= error_d;
      error_code <= code_d;
      dropped    <= dropped_d;
      good_count <= good_d;
    end
  end

  // Datapath: packet latch, bit-serial CRC, decrypt, byte index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt     <= '0;
      byp     <= 1'b0;
      crc     <= '0;
      crc_sh  <= '0;
      crc_cnt <= '0;
      pay     <= '0;
      csum    <= '0;
      idx     <= '0;
    end else begin
      case (state)
        S_IDLE: if (packet_valid) begin
          pkt <= packet_in[143:32];
          byp <= decrypt_bypass;
        end
        S_HDR: begin
          crc     <= CRC_INIT;
          crc_sh  <= pkt[103:56];
          crc_cnt <= '0;
        end
        S_CRC: begin
          crc     <= {crc[22:0], 1'b0} ^ ((crc[23] ^ crc_sh[47]) ? CRC_POLY : 24'h0);
          crc_sh  <= {crc_sh[46:0], 1'b0};
          crc_cnt <= crc_cnt + 6'd1;
        end
        S_DEC: begin
          pay <= pay_dec;
          csum <= csum_dec;
        end
        S_SEND: begin
          if (!tx_valid)     idx <= '0;
          else if (tx_ready) idx <= idx_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_host_specific_top_tx_to_host.sv
// Bench for host_specific_top_tx_to_host: a transaction-level model predicts
// every output each cycle from the packet rules and fixed latencies, and
// directed cases pin exact frames and timings with literal values.
module tb_host_specific_top_tx_to_host;

  localparam logic [15:0] KEY = 16'hA5C3;
  localparam logic [31:0] AA  = 32'h8E89BED6;

  logic         clk = 1'b0, reset = 1'b1;
  logic [143:0] packet_in = '0;
  logic         packet_valid = 1'b0, decrypt_bypass = 1'b0, tx_ready = 1'b1;
  logic         ready, tx_valid, done, error, dropped;
  logic [7:0]   tx_data, good_count;
  logic [1:0]   error_code;

  host_specific_top_tx_to_host dut (
    .clk(clk), .reset(reset), .packet_in(packet_in), .packet_valid(packet_valid),
    .decrypt_bypass(decrypt_bypass), .ready(ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done), .error(error),
    .error_code(error_code), .dropped(dropped), .good_count(good_count)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0, cyc = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [23:0] crc24(input logic [47:0] d);
    logic [23:0] c = 24'h555555;
    for (int i = 47; i >= 0; i--) begin
      logic fb = c[23] ^ d[i];
      c = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
    end
    return c;
  endfunction

  // kind: 0 good, 1 bad preamble, 2 bad access address, 3 bad cmd, 4 CRC bit flip
  function automatic logic [143:0] mk(input logic [7:0] cmd, input logic [7:0] len,
                                      input logic [31:0] pay, input int kind);
    logic [7:0]  pre = 8'hAA;
    logic [31:0] a = AA;
    logic [23:0] c = crc24({cmd, len, pay});
    if (kind == 1) pre = 8'hAB;
    if (kind == 2) a = a ^ 32'h1;
    if (kind == 3) cmd = cmd | 8'h40;
    if (kind == 3) c = crc24({cmd, len, pay});
    if (kind == 4) c = c ^ (24'h1 << $urandom_range(0, 23));
    return {pre, a, cmd, len, pay, c, 32'($urandom)};
  endfunction

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_ERR = 1, P_WAIT = 2, P_SEND = 3;
  int         phase = P_IDLE, t_evt = 0;
  logic       m_ready, m_tv, m_done, m_err, m_drop;
  logic [7:0] m_td, m_good;
  logic [1:0] m_code, p_code;
  logic [7:0] q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready = 1; m_tv = 0; m_td = 0; m_done = 0; m_err = 0; m_code = 0;
      m_drop = 0; m_good = 0; phase = P_IDLE; q.delete();
    end else begin
      cyc++;
      m_done = 0;
      m_drop = packet_valid && !m_ready;
      case (phase)
        P_IDLE: if (packet_valid) begin
          logic [7:0]  c, l, s;
          logic [31:0] p;
          logic [15:0] hi, lo;
          m_ready = 0; m_err = 0; m_code = 0;
          c = packet_in[103:96]; l = packet_in[95:88]; p = packet_in[87:56];
          if (packet_in[143:136] != 8'hAA || packet_in[135:104] != AA ||
              c[7:4] != 0 || c[3:0] == 0) begin
            p_code = 1; t_evt = cyc + 1; phase = P_ERR;
          end else if (l != 2 && l != 4) begin
            p_code = 3; t_evt = cyc + 1; phase = P_ERR;
          end else if (crc24(packet_in[103:56]) != packet_in[55:32]) begin
            p_code = 2; t_evt = cyc + 50; phase = P_ERR;
          end else begin
            hi = decrypt_bypass ? p[31:16] : p[31:16] ^ KEY;
            lo = decrypt_bypass ? p[15:0]  : p[15:0]  ^ KEY;
            q.delete();
            q.push_back(8'h7E); q.push_back(c); q.push_back(l);
            if (l == 4) begin q.push_back(hi[15:8]); q.push_back(hi[7:0]); end
            q.push_back(lo[15:8]); q.push_back(lo[7:0]);
            s = 0;
            for (int i = 1; i < q.size(); i++) s ^= q[i];
            q.push_back(s);
            t_evt = cyc + 51; phase = P_WAIT;
          end
        end
        P_ERR: if (cyc == t_evt) begin
          m_err = 1; m_code = p_code; m_ready = 1; phase = P_IDLE;
        end
        P_WAIT: if (cyc == t_evt) begin
          m_tv = 1; m_td = q[0]; phase = P_SEND;
        end
        P_SEND: if (tx_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_tv = 0; m_done = 1; m_ready = 1; m_good = m_good + 8'd1; phase = P_IDLE;
          end else m_td = q[0];
        end
        default: ;
      endcase
    end
  end

  // ---------------- compare + byte monitor ----------------
  logic [7:0] got[$];
  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      chk("ready", ready, m_ready);
      chk("tx_valid", tx_valid, m_tv);
      if (m_tv) chk("tx_data", tx_data, m_td);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("error_code", error_code, m_code);
      chk("dropped", dropped, m_drop);
      chk("good_count", good_count, m_good);
    end
    if (!reset && tx_valid && tx_ready) got.push_back(tx_data);
  end

  // ---------------- stimulus ----------------
  task automatic reset_vals(input string nm);
    chk({nm, "_ready"}, ready, 1);
    chk({nm, "_tx_valid"}, tx_valid, 0);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
    chk({nm, "_code"}, error_code, 0);
    chk({nm, "_dropped"}, dropped, 0);
    chk({nm, "_good"}, good_count, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  task automatic accept(input logic [143:0] p, input logic b);
    wait_ready();
    packet_in = p; decrypt_bypass = b; packet_valid = 1;
    @(posedge clk); #2;
    packet_valid = 0;
  endtask

  // Accepts a packet, returns the cycle offset of done (or -1) and of the
  // first cycle ready came back, plus the error flag just after accept.
  task automatic send(input logic [143:0] p, input logic b,
                      output int dk, output int rk, output logic e0);
    accept(p, b);
    e0 = error; dk = -1; rk = -1;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #2;
      if (done) begin dk = k; rk = k; break; end
      if (ready) begin rk = k; break; end
    end
    if (rk < 0) chk("send_timeout", ready, 1);
  endtask

  task automatic chk_frame(input string nm, input int base, input logic [7:0] e[], input int n);
    chk({nm, "_nbytes"}, got.size() - base, n);
    for (int i = 0; i < n && base + i < got.size(); i++) chk({nm, "_byte"}, got[base + i], e[i]);
  endtask

  initial begin
    int dk, rk, nb;
    logic e0;
    logic [7:0] f1[] = '{8'h7E, 8'h01, 8'h02, 8'hB7, 8'hF7, 8'h43};
    logic [7:0] f2[] = '{8'h7E, 8'h03, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h25};
    logic [7:0] f5[] = '{8'h7E, 8'h05, 8'h02, 8'h0E, 8'h0E, 8'h07};

    #12 reset_vals("rst");
    @(posedge clk); #2 reset = 0; cmp_en = 1;

    // Len 2 with decryption
    nb = got.size();
    send(mk(8'h01, 8'h02, 32'h0000_1234, 0), 0, dk, rk, e0);
    chk("t1_done_cycle", dk, 57);
    chk_frame("t1", nb, f1, 6);
    chk("t1_good", good_count, 1);

    // Len 4 bypassed
    nb = got.size();
    send(mk(8'h03, 8'h04, 32'hDEADBEEF, 0), 1, dk, rk, e0);
    chk("t2_done_cycle", dk, 59);
    chk_frame("t2", nb, f2, 8);

    // Bad access address, then a good packet clears the error
    nb = got.size();
    send(mk(8'h01, 8'h02, 32'h0000_5555, 2), 0, dk, rk, e0);
    chk("t3_err_cycle", rk, 1);
    chk("t3_error", error, 1);
    chk("t3_code", error_code, 1);
    chk("t3_nbytes", got.size() - nb, 0);
    send(mk(8'h02, 8'h02, 32'h0000_0001, 0), 0, dk, rk, e0);
    chk("t3_err_cleared", e0, 0);

    // CRC error and length error
    send(mk(8'h04, 8'h04, 32'h01020304, 4), 0, dk, rk, e0);
    chk("t4_crc_cycle", rk, 50);
    chk("t4_crc_code", error_code, 2);
    send(mk(8'h04, 8'h03, 32'h01020304, 0), 0, dk, rk, e0);
    chk("t4_len_cycle", rk, 1);
    chk("t4_len_code", error_code, 3);

    // Backpressure on the third byte with packets offered while busy
    nb = got.size(); dk = -1;
    accept(mk(8'h05, 8'h02, 32'h0000_ABCD, 0), 0);
    packet_in = mk(8'h09, 8'h04, 32'h11111111, 0);
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk); #2;
      if (done) begin dk = k; break; end
      if (k >= 54 && k <= 58) chk("t5_hold", tx_data, 8'h02);
      if (k == 56 || k == 57) chk("t5_dropped", dropped, 1);
      tx_ready = !(k >= 53 && k <= 57);
      packet_valid = (k == 55 || k == 56);
    end
    tx_ready = 1; packet_valid = 0;
    chk("t5_done_cycle", dk, 62);
    chk_frame("t5", nb, f5, 6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c, l;
      int r;
      @(posedge clk); #2;
      tx_ready = ($urandom_range(0, 3) != 0);
      packet_valid = ($urandom_range(0, 9) == 0);
      decrypt_bypass = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {4'h0, 4'($urandom_range(1, 15))};
      r = $urandom_range(0, 9);
      l = (r == 0) ? 8'($urandom) : (r < 5 ? 8'd2 : 8'd4);
      r = $urandom_range(0, 8);
      packet_in = mk(c, l, $urandom, r > 4 ? 0 : r);
    end
    packet_valid = 0; tx_ready = 1;
    wait_ready();

    // Reset in the middle of SEND
    accept(mk(8'h06, 8'h04, 32'hCAFEF00D, 0), 0);
    repeat (52) @(posedge clk);
    #1 reset = 1;
    #1 reset_vals("midrst");
    @(posedge clk); #2 reset = 0;

    // 256 good frames wrap the counter
    for (int i = 0; i < 256; i++) begin
      send(mk({4'h0, 4'($urandom_range(1, 15))}, ($urandom_range(0, 1) == 1) ? 8'd4 : 8'd2,
              $urandom, 0), $urandom_range(0, 1) == 1, dk, rk, e0);
      if (i == 254) chk("t7_count255", good_count, 255);
    end
    chk("t7_wrap", good_count, 0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
